// File: rtl/flight_mode_controller.sv
// Sequencing controller for the x/y/z axis position units: accepts flight commands,
// drives the one-hot velocity-mode and position selects, and times warp and stealth.
module flight_mode_controller #(
  parameter int CHARGE_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int STEALTH_MAX     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [3:0] mode_sel,
  output logic [3:0] pos_sel,
  output logic [2:0] state,
  output logic       err,
  output logic       stealth_expired
);

  localparam int PHASE_MAX = (CHARGE_CYCLES > COOLDOWN_CYCLES) ? CHARGE_CYCLES : COOLDOWN_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int SW = $clog2(STEALTH_MAX + 1);

  localparam logic [3:0] MODE_RESET   = 4'b0001;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;
  localparam logic [3:0] POS_ZERO     = 4'b0001;
  localparam logic [3:0] POS_ACC      = 4'b0010;
  localparam logic [3:0] POS_WARP     = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CRUISE   = 3'd1,
    ST_CHARGE   = 3'd2,
    ST_JUMP     = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    mode_reg, mode_next;
  logic [3:0]    pos_reg, pos_next;
  logic [PW-1:0] phase_cnt_reg, phase_cnt_next;
  logic [SW-1:0] stealth_cnt_reg, stealth_cnt_next;
  logic          ready_reg, ready_next;
  logic          err_reg, err_next;
  logic          expired_reg, expired_next;

  logic          accept;
  logic          op_is_mode;
  logic [3:0]    op_mode;
  logic          phase_last;
  logic [PW-1:0] phase_dec;
  logic          stealth_limit;

  assign accept     = cmd_valid & ready_reg;
  assign op_is_mode = (cmd_op != 3'd0) && (cmd_op <= 3'd3);
  // Ops 0..3 map directly onto the one-hot mode encoding.
  assign op_mode    = 4'b0001 << cmd_op[1:0];
  assign phase_last = (phase_cnt_reg <= PW'(1));
  assign phase_dec  = (phase_cnt_reg == '0) ? '0 : phase_cnt_reg - PW'(1);
  // True during the STEALTH_MAX-th consecutive stealth cycle.
  assign stealth_limit = (mode_reg == MODE_STEALTH) && (stealth_cnt_reg >= SW'(STEALTH_MAX - 1));

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    phase_cnt_next = phase_cnt_reg;
    err_next       = 1'b0;
    expired_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_mode) begin
            state_next = ST_CRUISE;
            mode_next  = op_mode;
          end else if (cmd_op != 3'd0) begin
            err_next = 1'b1;
          end
        end
      end
      ST_CRUISE: begin
        if (accept) begin
          if (cmd_op == 3'd0) begin
            state_next = ST_IDLE;
            mode_next  = MODE_RESET;
          end else if (op_is_mode) begin
            mode_next = op_mode;
          end else if (cmd_op == 3'd4 && mode_reg != MODE_STEALTH) begin
            state_next     = ST_CHARGE;
            phase_cnt_next = PW'(CHARGE_CYCLES);
          end else begin
            err_next = 1'b1;
          end
        end else if (stealth_limit) begin
          mode_next    = MODE_DEFENSE;
          expired_next = 1'b1;
        end
      end
      ST_CHARGE: begin
        // abort takes priority over the expiry edge.
        if (abort) begin
          state_next     = ST_CRUISE;
          phase_cnt_next = '0;
        end else if (phase_last) begin
          state_next     = ST_JUMP;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_dec;
        end
      end
      ST_JUMP: begin
        state_next     = ST_COOLDOWN;
        phase_cnt_next = PW'(COOLDOWN_CYCLES);
      end
      ST_COOLDOWN: begin
        if (phase_last) begin
          state_next     = ST_CRUISE;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_dec;
        end
        if (accept) begin
          if (cmd_op == 3'd0) begin
            state_next     = ST_IDLE;
            mode_next      = MODE_RESET;
            phase_cnt_next = '0;
          end else if (op_is_mode) begin
            mode_next = op_mode;
          end else begin
            err_next = 1'b1;
          end
        end else if (stealth_limit) begin
          mode_next    = MODE_DEFENSE;
          expired_next = 1'b1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        mode_next      = MODE_RESET;
        phase_cnt_next = '0;
      end
    endcase

    // Timer restarts only on entry to stealth; a repeated stealth command keeps counting.
    stealth_cnt_next = '0;
    if (mode_next == MODE_STEALTH) begin
      if (mode_reg != MODE_STEALTH)
        stealth_cnt_next = '0;
      else if (stealth_cnt_reg < SW'(STEALTH_MAX))
        stealth_cnt_next = stealth_cnt_reg + SW'(1);
      else
        stealth_cnt_next = stealth_cnt_reg;
    end

    pos_next   = POS_ACC;
    ready_next = 1'b1;
    case (state_next)
      ST_IDLE:   pos_next = POS_ZERO;
      ST_CHARGE: ready_next = 1'b0;
      ST_JUMP: begin
        pos_next   = POS_WARP;
        ready_next = 1'b0;
      end
      default: begin
        pos_next   = POS_ACC;
        ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= MODE_RESET;
      pos_reg         <= POS_ZERO;
      phase_cnt_reg   <= '0;
      stealth_cnt_reg <= '0;
      ready_reg       <= 1'b1;
      err_reg         <= 1'b0;
      expired_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mode_reg        <= mode_next;
      pos_reg         <= pos_next;
      phase_cnt_reg   <= phase_cnt_next;
      stealth_cnt_reg <= stealth_cnt_next;
      ready_reg       <= ready_next;
      err_reg         <= err_next;
      expired_reg     <= expired_next;
    end
  end

  assign state           = state_reg;
  assign mode_sel        = mode_reg;
  assign pos_sel         = pos_reg;
  assign cmd_ready       = ready_reg;
  assign err             = err_reg;
  assign stealth_expired = expired_reg;

endmodule

// File: tb/tb_flight_mode_controller.sv
// Directed bench for flight_mode_controller: command decode, warp timing, rejections,
// stealth limit, abort and asynchronous reset, checked with immediate assertions.
module tb_flight_mode_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       abort;
  logic [3:0] mode_sel;
  logic [3:0] pos_sel;
  logic [2:0] state;
  logic       err;
  logic       stealth_expired;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int warp_seen = 0;
  int exp_seen  = 0;

  flight_mode_controller #(
    .CHARGE_CYCLES(8),
    .COOLDOWN_CYCLES(16),
    .STEALTH_MAX(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(cmd_ready),
    .abort(abort),
    .mode_sel(mode_sel),
    .pos_sel(pos_sel),
    .state(state),
    .err(err),
    .stealth_expired(stealth_expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 ns after the next rising edge and note warp/expiry pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pos_sel == 4'b0100) warp_seen++;
    if (stealth_expired) exp_seen++;
  endtask

  task automatic send(input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    $display("cmd op=%0d -> state=%0d mode=%b pos=%b err=%b ready=%b",
             op, state, mode_sel, pos_sel, err, cmd_ready);
  endtask

  initial begin
    logic [2:0] exp_state;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    abort     = 1'b0;

    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_mode", 32'(mode_sel), 32'h1);
    check("rst_pos", 32'(pos_sel), 32'h1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_expired", 32'(stealth_expired), 32'd0);
    tick();
    rst = 1'b0;

    // Basic mode entry and exit.
    send(3'd1);
    check("attack_state", 32'(state), 32'd1);
    check("attack_mode", 32'(mode_sel), 32'h2);
    check("attack_pos", 32'(pos_sel), 32'h2);
    send(3'd0);
    check("idle_state", 32'(state), 32'd0);
    check("idle_pos", 32'(pos_sel), 32'h1);
    check("idle_mode", 32'(mode_sel), 32'h1);

    // Full warp from attack, checked cycle by cycle T..T+25.
    send(3'd1);
    warp_seen = 0;
    send(3'd4);
    for (int k = 0; k <= 25; k++) begin
      exp_state = (k < 8) ? 3'd2 : (k == 8) ? 3'd3 : (k <= 24) ? 3'd4 : 3'd1;
      check($sformatf("warp_state_c%0d", k), 32'(state), 32'(exp_state));
      check($sformatf("warp_pos_c%0d", k), 32'(pos_sel), (k == 8) ? 32'h4 : 32'h2);
      check($sformatf("warp_ready_c%0d", k), 32'(cmd_ready), (k <= 8) ? 32'd0 : 32'd1);
      if (k < 25) tick();
    end
    check("warp_pulses", 32'(warp_seen), 32'd1);
    check("warp_mode", 32'(mode_sel), 32'h2);

    // Rejections: warp in stealth, warp in IDLE, invalid op, warp in COOLDOWN.
    send(3'd3);
    check("stealth_mode", 32'(mode_sel), 32'h8);
    send(3'd4);
    check("rej_stealth_err", 32'(err), 32'd1);
    check("rej_stealth_state", 32'(state), 32'd1);
    check("rej_stealth_mode", 32'(mode_sel), 32'h8);
    check("rej_stealth_pos", 32'(pos_sel), 32'h2);
    tick();
    check("rej_err_clear", 32'(err), 32'd0);
    send(3'd0);
    send(3'd4);
    check("rej_idle_err", 32'(err), 32'd1);
    check("rej_idle_state", 32'(state), 32'd0);
    check("rej_idle_mode", 32'(mode_sel), 32'h1);
    check("rej_idle_pos", 32'(pos_sel), 32'h1);
    send(3'd6);
    check("rej_op6_err", 32'(err), 32'd1);
    check("rej_op6_state", 32'(state), 32'd0);
    check("rej_op6_mode", 32'(mode_sel), 32'h1);
    tick();
    check("rej_op6_err_clear", 32'(err), 32'd0);
    send(3'd2);
    send(3'd4);
    repeat (9) tick();
    check("cool_entry", 32'(state), 32'd4);
    send(3'd4);
    check("rej_cool_err", 32'(err), 32'd1);
    check("rej_cool_state", 32'(state), 32'd4);
    check("rej_cool_mode", 32'(mode_sel), 32'h4);
    check("rej_cool_pos", 32'(pos_sel), 32'h2);
    send(3'd0);
    check("cool_exit_state", 32'(state), 32'd0);
    check("cool_exit_pos", 32'(pos_sel), 32'h1);

    // Stealth held for 64 cycles forces defense with a single pulse.
    exp_seen = 0;
    send(3'd3);
    repeat (63) tick();
    check("stealth_hold_mode", 32'(mode_sel), 32'h8);
    check("stealth_hold_nopulse", 32'(exp_seen), 32'd0);
    tick();
    check("stealth_expire_mode", 32'(mode_sel), 32'h4);
    check("stealth_expire_pulse", 32'(stealth_expired), 32'd1);
    tick();
    check("stealth_pulse_clear", 32'(stealth_expired), 32'd0);
    check("stealth_pulse_count", 32'(exp_seen), 32'd1);
    check("stealth_state", 32'(state), 32'd1);

    // Command on the expiry cycle wins: no pulse.
    exp_seen = 0;
    send(3'd3);
    repeat (63) tick();
    check("win_hold_mode", 32'(mode_sel), 32'h8);
    send(3'd2);
    check("win_mode", 32'(mode_sel), 32'h4);
    check("win_nopulse", 32'(stealth_expired), 32'd0);
    tick();
    check("win_pulse_count", 32'(exp_seen), 32'd0);

    // Abort during CHARGE cycle 3.
    warp_seen = 0;
    send(3'd4);
    repeat (3) tick();
    check("abort3_charge", 32'(state), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort3_state", 32'(state), 32'd1);
    check("abort3_pos", 32'(pos_sel), 32'h2);
    check("abort3_ready", 32'(cmd_ready), 32'd1);
    repeat (10) tick();
    check("abort3_stay", 32'(state), 32'd1);
    check("abort3_nowarp", 32'(warp_seen), 32'd0);

    // Abort coincident with the counter-expiry edge.
    send(3'd4);
    repeat (7) tick();
    check("abort_exp_charge", 32'(state), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_exp_state", 32'(state), 32'd1);
    check("abort_exp_pos", 32'(pos_sel), 32'h2);
    repeat (3) tick();
    check("abort_exp_nowarp", 32'(warp_seen), 32'd0);

    // Asynchronous reset between edges while charging.
    send(3'd4);
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_mode", 32'(mode_sel), 32'h1);
    check("arst_pos", 32'(pos_sel), 32'h1);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    check("arst_nowarp", 32'(warp_seen), 32'd0);
    rst = 1'b0;
    send(3'd3);
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_mode", 32'(mode_sel), 32'h8);
    check("post_rst_pos", 32'(pos_sel), 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
